// File: rtl/instr_tx.sv
// Sends one 16-bit instruction to the switch/button instruction loader as two
// button-strobed bytes: byte0 {instr[3:0],opcode} then byte1 instr[11:4].
// Latency: SETUP starts 1 cycle after acceptance (2 with INSTR_TX_FIFO_EN);
// 2*(SETUP_CYCLES+2*HOLD_CYCLES) busy cycles, then a one-cycle done pulse.
// Backpressure: in_ready = idle (no FIFO) or FIFO not full (INSTR_TX_FIFO_EN).
// Build option: define INSTR_TX_FIFO_EN to buffer up to 4 instructions.

module instr_tx #(
   parameter int SETUP_CYCLES = 2,   // dip_out stable cycles before btn rises, 1..255
   parameter int HOLD_CYCLES  = 4    // btn high cycles, then btn low cycles, 3..255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  in_opcode,
   input  logic [11:0] in_instr,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  dip_out,
   output logic        btn_out,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_HIGH  = 2'd2,
      S_LOW   = 2'd3
   } state_t;

   // Counter reload values: a phase of N cycles loads N-1 and ends at zero.
   localparam logic [7:0] LP_SETUP_LD = 8'(SETUP_CYCLES - 1);
   localparam logic [7:0] LP_HOLD_LD  = 8'(HOLD_CYCLES - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_bsel;        // 0 while sending byte0, 1 while sending byte1
   logic        w_bsel_nxt;
   logic [7:0]  r_cnt;         // cycles remaining in the current phase, minus one
   logic [7:0]  w_cnt_nxt;
   logic [7:0]  r_byte1;       // second byte held from capture until its SETUP
   logic [7:0]  w_byte1_nxt;
   logic [7:0]  r_dip;
   logic [7:0]  w_dip_nxt;
   logic        r_btn;
   logic        w_btn_nxt;
   logic        r_done;
   logic        w_done_nxt;

   // Start of a new instruction and the 16-bit word it sends ({instr, opcode}).
   logic        w_start;
   logic [15:0] w_start_dat;

`ifdef INSTR_TX_FIFO_EN

   logic [15:0] r_fifo_mem [4];
   logic [1:0]  r_wr_ptr;
   logic [1:0]  r_rd_ptr;
   logic [2:0]  r_fifo_cnt;
   logic        w_push;
   logic        w_full;
   logic        w_empty;

   assign w_full      = (r_fifo_cnt == 3'd4);
   assign w_empty     = (r_fifo_cnt == 3'd0);
   assign in_ready    = ~w_full;
   assign w_push      = in_valid & ~w_full;
   // IDLE (including the done cycle) pops the head whenever one is waiting.
   assign w_start     = (r_state == S_IDLE) & ~w_empty;
   assign w_start_dat = r_fifo_mem[r_rd_ptr];

   // FIFO pointers and occupancy; push and pop in the same cycle both happen.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr   <= 2'd0;
         r_rd_ptr   <= 2'd0;
         r_fifo_cnt <= 3'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 2'd1;
         end
         if (w_start) begin
            r_rd_ptr <= r_rd_ptr + 2'd1;
         end
         r_fifo_cnt <= r_fifo_cnt + {2'b00, w_push} - {2'b00, w_start};
      end
   end

   // FIFO storage; entries are only meaningful between their push and pop.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_mem[r_wr_ptr] <= {in_instr, in_opcode};
      end
   end

`else

   // Without buffering the instruction is taken straight from the inputs, and
   // only in IDLE (the done cycle counts as IDLE), so in_valid while busy is ignored.
   assign in_ready    = (r_state == S_IDLE);
   assign w_start     = in_valid & in_ready;
   assign w_start_dat = {in_instr, in_opcode};

`endif

   // State, byte select, phase counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_bsel  <= 1'b0;
         r_cnt   <= 8'd0;
         r_byte1 <= 8'd0;
         r_dip   <= 8'd0;
         r_btn   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_bsel  <= w_bsel_nxt;
         r_cnt   <= w_cnt_nxt;
         r_byte1 <= w_byte1_nxt;
         r_dip   <= w_dip_nxt;
         r_btn   <= w_btn_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Phase sequencing: SETUP -> HIGH -> LOW per byte, byte0 then byte1, then IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_bsel_nxt  = r_bsel;
      w_cnt_nxt   = r_cnt;
      w_byte1_nxt = r_byte1;
      w_dip_nxt   = r_dip;
      w_done_nxt  = 1'b0;

      case (r_state)
         S_IDLE: begin
            // dip_out keeps its last byte while idle; byte0 appears with SETUP.
            if (w_start) begin
               w_state_nxt = S_SETUP;
               w_bsel_nxt  = 1'b0;
               w_cnt_nxt   = LP_SETUP_LD;
               w_dip_nxt   = w_start_dat[7:0];
               w_byte1_nxt = w_start_dat[15:8];
            end
         end
         S_SETUP: begin
            if (r_cnt == 8'd0) begin
               w_state_nxt = S_HIGH;
               w_cnt_nxt   = LP_HOLD_LD;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         S_HIGH: begin
            if (r_cnt == 8'd0) begin
               w_state_nxt = S_LOW;
               w_cnt_nxt   = LP_HOLD_LD;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         S_LOW: begin
            if (r_cnt == 8'd0) begin
               if (!r_bsel) begin
                  // dip_out changes only here, at the first byte1 SETUP cycle.
                  w_state_nxt = S_SETUP;
                  w_bsel_nxt  = 1'b1;
                  w_cnt_nxt   = LP_SETUP_LD;
                  w_dip_nxt   = r_byte1;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_bsel_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_bsel_nxt  = 1'b0;
         end
      endcase

      // The button is high exactly in HIGH cycles; registering it from the
      // next state keeps the pin glitch-free and aligned with the state.
      w_btn_nxt = (w_state_nxt == S_HIGH);
   end

   assign dip_out = r_dip;
   assign btn_out = r_btn;
   assign busy    = (r_state != S_IDLE);
   assign done    = r_done;

endmodule

// File: tb/tb_instr_tx.sv
// Bench for instr_tx: default-parameter DUT plus a SETUP=1/HOLD=3 DUT.
// Expected waveforms come from per-cycle arithmetic on the phase lengths.
// Includes a behavioural model of the downstream instruction loader.

module tb_instr_tx;

`ifdef INSTR_TX_FIFO_EN
   localparam int LAT = 2;        // acceptance to first SETUP cycle
   localparam bit FIFO = 1'b1;
`else
   localparam int LAT = 1;
   localparam bit FIFO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  in_opcode;
   logic [11:0] in_instr;
   logic        vld_a, vld_b;
   logic        rdy1, btn1, busy1, done1;
   logic        rdy2, btn2, busy2, done2;
   logic [7:0]  dip1, dip2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   instr_tx u_dut (
      .clk(clk), .rst_n(rst_n), .in_opcode(in_opcode), .in_instr(in_instr),
      .in_valid(vld_a), .in_ready(rdy1), .dip_out(dip1), .btn_out(btn1),
      .busy(busy1), .done(done1)
   );

   instr_tx #(.SETUP_CYCLES(1), .HOLD_CYCLES(3)) u_dut_short (
      .clk(clk), .rst_n(rst_n), .in_opcode(in_opcode), .in_instr(in_instr),
      .in_valid(vld_b), .in_ready(rdy2), .dip_out(dip2), .btn_out(btn2),
      .busy(busy2), .done(done2)
   );

   // Observation mux so the transfer checker can watch either DUT.
   int         dsel = 0;
   logic [7:0] o_dip;
   logic       o_btn, o_busy, o_done, o_rdy;
   always_comb begin
      if (dsel == 0) begin
         o_dip = dip1; o_btn = btn1; o_busy = busy1; o_done = done1; o_rdy = rdy1;
      end else begin
         o_dip = dip2; o_btn = btn2; o_busy = busy2; o_done = done2; o_rdy = rdy2;
      end
   end

   // Loader model and monitors: the loader latches dip_out on each button press.
   logic        btn1_q = 1'b0, btn2_q = 1'b0;
   int          edges2 = 0, busy1_cnt = 0, busy2_cnt = 0, cap_n = 0;
   logic [7:0]  cap_mem [64];
   logic [3:0]  ld_op = 4'd0;
   logic [11:0] ld_instr = 12'd0;
   logic        ld_flag = 1'b0;
   logic [7:0]  last_dip [2];

   always @(posedge clk) begin
      btn1_q <= btn1;
      btn2_q <= btn2;
      if (busy1) busy1_cnt <= busy1_cnt + 1;
      if (busy2) busy2_cnt <= busy2_cnt + 1;
      if (btn2 && !btn2_q) edges2 <= edges2 + 1;
      if (btn1 && !btn1_q) begin
         cap_mem[cap_n % 64] <= dip1;
         cap_n <= cap_n + 1;
      end
      if (!rst_n) begin
         ld_flag <= 1'b0;
      end else if (btn1 && !btn1_q) begin
         if (!ld_flag) begin
            ld_op          <= dip1[3:0];
            ld_instr[3:0]  <= dip1[7:4];
            ld_flag        <= 1'b1;
         end else begin
            ld_instr[11:4] <= dip1;
            ld_flag        <= 1'b0;
         end
      end
   end

   // Offer one instruction to DUT d and check every cycle through its done cycle.
   task automatic check_xfer(input int d, input logic [3:0] op, input logic [11:0] ins,
                             input int s, input int h);
      logic [7:0]  b0, b1, e_dip;
      logic        e_btn, e_busy, e_done, e_rdy;
      int          p, kk, off;
      b0 = {ins[3:0], op};
      b1 = ins[11:4];
      p  = s + 2 * h;
      dsel = d;
      in_opcode = op;
      in_instr  = ins;
      if (d == 0) vld_a = 1'b1; else vld_b = 1'b1;
      #1;
      checks++;
      if (o_rdy !== 1'b1) begin
         errors++;
         $display("FAIL accept_ready dut%0d: got %b want 1", d, o_rdy);
      end
      @(posedge clk); #1;
      vld_a = 1'b0; vld_b = 1'b0;
      in_opcode = 4'($urandom);
      in_instr  = 12'($urandom);
      for (int k = 1; k <= 2 * p + LAT; k++) begin
         @(negedge clk);
         kk = k - (LAT - 1);
         if (kk == 0) begin
            e_dip = last_dip[d]; e_btn = 1'b0; e_busy = 1'b0; e_done = 1'b0;
         end else if (kk <= 2 * p) begin
            off    = (kk - 1) % p;
            e_dip  = (((kk - 1) / p) != 0) ? b1 : b0;
            e_btn  = (off >= s) && (off < s + h);
            e_busy = 1'b1;
            e_done = 1'b0;
         end else begin
            e_dip = b1; e_btn = 1'b0; e_busy = 1'b0; e_done = 1'b1;
         end
         e_rdy = FIFO ? 1'b1 : ~e_busy;
         checks++;
         if ({o_dip, o_btn, o_busy, o_done, o_rdy} !== {e_dip, e_btn, e_busy, e_done, e_rdy}) begin
            errors++;
            $display("FAIL xfer dut%0d op=%h ins=%h cycle %0d: got dip/btn/busy/done/rdy=%h/%b/%b/%b/%b want %h/%b/%b/%b/%b",
                     d, op, ins, k, o_dip, o_btn, o_busy, o_done, o_rdy,
                     e_dip, e_btn, e_busy, e_done, e_rdy);
         end
      end
      last_dip[d] = b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      vld_a = 1'b1; vld_b = 1'b1;
      in_opcode = 4'hF; in_instr = 12'hFFF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         dsel = d; #1;
         checks++;
         if ({o_dip, o_btn, o_busy, o_done, o_rdy} !== 12'b0000_0000_0001) begin
            errors++;
            $display("FAIL reset_state dut%0d: got %h want 001", d, {o_dip, o_btn, o_busy, o_done, o_rdy});
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b1; vld_a = 1'b0; vld_b = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy1, busy2} !== 2'b00) begin
         errors++;
         $display("FAIL reset_valid_ignored: got busy=%b%b want 00", busy1, busy2);
      end
      last_dip[0] = 8'h00; last_dip[1] = 8'h00;
   endtask

   task automatic test_directed();
      int b;
      b = busy1_cnt;
      check_xfer(0, 4'hA, 12'h5C3, 2, 4);
      checks++;
      if (busy1_cnt - b !== 20) begin
         errors++;
         $display("FAIL busy_cycles: got %0d want 20", busy1_cnt - b);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         check_xfer(0, 4'($urandom), 12'($urandom), 2, 4);
      end
   endtask

   task automatic test_loader();
      check_xfer(0, 4'h1, 12'hABC, 2, 4);
      checks++;
      if ({ld_op, ld_instr, ld_flag} !== {4'h1, 12'hABC, 1'b0}) begin
         errors++;
         $display("FAIL loader: got op=%h instr=%h flag=%b want 1/abc/0", ld_op, ld_instr, ld_flag);
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      dsel = 0;
      in_opcode = 4'($urandom); in_instr = 12'($urandom);
      vld_a = 1'b1;
      #1;
      @(posedge clk); #1;
      vld_a = 1'b0;
      for (int k = 1; k <= 14 + LAT - 1; k++) @(negedge clk);
      checks++;
      if (btn1 !== 1'b1) begin
         errors++;
         $display("FAIL byte1_high: got btn=%b want 1", btn1);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({dip1, btn1, busy1, done1, rdy1} !== 12'b0000_0000_0001) begin
         errors++;
         $display("FAIL reset_mid: got dip/btn/busy/done/rdy=%h/%b/%b/%b/%b want 00/0/0/0/1",
                  dip1, btn1, busy1, done1, rdy1);
      end
      bad = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (done1 || busy1) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL reset_mid_quiet: got %0d busy/done cycles want 0", bad);
      end
      last_dip[0] = 8'h00; last_dip[1] = 8'h00;
   endtask

`ifndef INSTR_TX_FIFO_EN
   task automatic test_busy_ignore();
      logic [3:0]  op, nop;
      logic [11:0] ins, nins;
      logic        found;
      op = 4'($urandom); ins = 12'($urandom);
      dsel = 0;
      in_opcode = op; in_instr = ins; vld_a = 1'b1;
      #1;
      @(posedge clk); #1;
      in_opcode = 4'($urandom); in_instr = 12'($urandom);
      for (int k = 1; k <= 21; k++) begin
         @(negedge clk);
         checks++;
         if ({rdy1, done1, dip1} !== {(k == 21), (k == 21), (k <= 10) ? {ins[3:0], op} : ins[11:4]}) begin
            errors++;
            $display("FAIL busy_ignore cycle %0d: got rdy/done/dip=%b/%b/%h want %b/%b/%h", k, rdy1, done1, dip1,
                     (k == 21), (k == 21), (k <= 10) ? {ins[3:0], op} : ins[11:4]);
         end
         if (k < 21) begin
            @(posedge clk); #1;
            in_opcode = 4'($urandom); in_instr = 12'($urandom);
         end
      end
      nop = in_opcode; nins = in_instr;
      @(posedge clk); #1;
      vld_a = 1'b0;
      in_opcode = 4'($urandom); in_instr = 12'($urandom);
      @(negedge clk);
      checks++;
      if ({busy1, dip1} !== {1'b1, nins[3:0], nop}) begin
         errors++;
         $display("FAIL accept_on_done: got busy/dip=%b/%h want 1/%h", busy1, dip1, {nins[3:0], nop});
      end
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         @(negedge clk);
         if (done1) found = 1'b1;
      end
      checks++;
      if ({found, dip1} !== {1'b1, nins[11:4]}) begin
         errors++;
         $display("FAIL second_done: got found/dip=%b/%h want 1/%h", found, dip1, nins[11:4]);
      end
      last_dip[0] = nins[11:4];
   endtask
`endif

`ifdef INSTR_TX_FIFO_EN
   task automatic test_fifo();
      logic [3:0]  op [5];
      logic [11:0] ins [5];
      int          done_t [5];
      int          nd, pushed, cs, extra;
      logic        acc;
      for (int i = 0; i < 5; i++) begin
         op[i] = 4'($urandom); ins[i] = 12'($urandom);
      end
      nd = 0; pushed = 0; extra = 0;
      cs = cap_n;
      @(negedge clk);
      in_opcode = op[0]; in_instr = ins[0]; vld_a = 1'b1;
      for (int c = 0; c < 116; c++) begin
         #1;
         acc = vld_a && rdy1;
         if (done1) begin
            if (nd < 5) done_t[nd] = c; else extra++;
            nd++;
         end
         if (c == 5) begin
            checks++;
            if ({pushed, rdy1} !== {32'd5, 1'b0}) begin
               errors++;
               $display("FAIL fifo_full: got pushed=%0d rdy=%b want 5/0", pushed, rdy1);
            end
         end
         if (c == 21 || c == 23) begin
            checks++;
            if (rdy1 !== (c == 23)) begin
               errors++;
               $display("FAIL fifo_ready cycle %0d: got %b want %b", c, rdy1, (c == 23));
            end
         end
         @(posedge clk); #1;
         if (acc) begin
            pushed++;
            if (pushed < 5) begin
               in_opcode = op[pushed]; in_instr = ins[pushed];
            end else begin
               vld_a = 1'b0;
            end
         end
         @(negedge clk);
      end
      checks++;
      if ({nd, extra} !== {32'd5, 32'd0}) begin
         errors++;
         $display("FAIL fifo_done_count: got %0d want 5", nd);
      end
      for (int i = 0; i < 5 && i < nd; i++) begin
         checks++;
         if (done_t[i] !== 22 + 21 * i) begin
            errors++;
            $display("FAIL fifo_done_time %0d: got %0d want %0d", i, done_t[i], 22 + 21 * i);
         end
      end
      checks++;
      if (cap_n - cs !== 10) begin
         errors++;
         $display("FAIL fifo_bytes: got %0d presses want 10", cap_n - cs);
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if ({cap_mem[(cs + 2 * i) % 64], cap_mem[(cs + 2 * i + 1) % 64]} !== {ins[i][3:0], op[i], ins[i][11:4]}) begin
               errors++;
               $display("FAIL fifo_order %0d: got %h%h want %h%h", i, cap_mem[(cs + 2 * i) % 64],
                        cap_mem[(cs + 2 * i + 1) % 64], {ins[i][3:0], op[i]}, ins[i][11:4]);
            end
         end
      end
      last_dip[0] = ins[4][11:4];
   endtask
`endif

   task automatic test_short();
      int b, e;
      b = busy2_cnt;
      e = edges2;
      check_xfer(1, 4'($urandom), 12'($urandom), 1, 3);
      checks++;
      if ({busy2_cnt - b, edges2 - e} !== {32'd14, 32'd2}) begin
         errors++;
         $display("FAIL short_params: got busy=%0d edges=%0d want 14/2", busy2_cnt - b, edges2 - e);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      vld_a = 1'b0; vld_b = 1'b0;
      in_opcode = 4'd0; in_instr = 12'd0;
      last_dip[0] = 8'h00; last_dip[1] = 8'h00;
      test_reset();
      test_directed();
      test_random();
      test_loader();
      test_reset_mid();
`ifdef INSTR_TX_FIFO_EN
      test_fifo();
`else
      test_busy_ignore();
`endif
      test_short();
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_tx.md
INSTR_TX -- requirements
Module: instr_tx

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 2, cycles dip_out is stable before btn_out rises (legal 1..255).
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, cycles btn_out stays high and then stays low per byte (legal 3..255).
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_opcode  input  4  opcode of instruction to send.
REQ-006 SHALL have port in_instr  input  12  instruction operand field to send.
REQ-007 SHALL have port in_valid  input  1  instruction offered.
REQ-008 SHALL have port in_ready  output  1  instruction accepted when in_valid and in_ready are both high at a rising edge.
REQ-009 SHALL have port dip_out  output  8  byte presented to the switch-input port of the instruction loader.
REQ-010 SHALL have port btn_out  output  1  push-button level driven to the loader's button input.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when both bytes of an instruction are sent.

Function
REQ-013 SHALL send each instruction as two button-strobed bytes: byte0 = {in_instr[3:0], in_opcode}, then byte1 = in_instr[11:4].
REQ-014 SHALL implement states IDLE, SETUP, HIGH, LOW and a byte-select bit; each byte runs SETUP (SETUP_CYCLES) -> HIGH (HOLD_CYCLES) -> LOW (HOLD_CYCLES).
REQ-015 SHALL capture the instruction on acceptance and enter SETUP for byte0 on the next cycle, with dip_out = byte0 and btn_out = 0 in that cycle.
REQ-016 SHALL drive btn_out = 1 exactly in HIGH cycles and 0 in all other states.
REQ-017 SHALL hold dip_out constant from the first SETUP cycle to the last LOW cycle of a byte; dip_out switches to byte1 in the first byte1 SETUP cycle.
REQ-018 SHALL go from byte0 LOW end to byte1 SETUP, and from byte1 LOW end to IDLE, asserting done in that first IDLE cycle only.
REQ-019 SHALL take exactly 2*(SETUP_CYCLES + 2*HOLD_CYCLES) non-IDLE cycles per instruction (20 with defaults).
REQ-020 SHALL keep dip_out at its last value in IDLE; changing in_opcode/in_instr after acceptance has no effect.
REQ-021 SHALL use an 8-bit down counter for phase timing; no phase is shortened or extended by in_valid activity.
REQ-022 SHALL produce exactly one btn_out rising edge per byte, i.e. two per instruction, never more.

Reset
REQ-023 SHALL, while rst_n is low at a rising edge, set state IDLE, byte-select 0, dip_out = 0, btn_out = 0, busy = 0, done = 0, and in_ready per REQ-026/REQ-027 (empty FIFO).
REQ-024 SHALL abandon any transfer on reset mid-operation: btn_out low the cycle after reset, no done pulse, captured instruction discarded.
REQ-025 SHALL ignore in_valid during cycles in which rst_n is low.

Configuration
REQ-026 SHALL, when macro INSTR_TX_FIFO_EN is defined, include a 4-entry FIFO: in_ready = not full; IDLE pops head when non-empty and enters SETUP next cycle; push into empty FIFO starts SETUP two cycles after acceptance; back-to-back instructions separated by exactly one IDLE (done) cycle; push and pop in the same cycle are both honoured; reset flushes the FIFO.
REQ-027 SHALL, when INSTR_TX_FIFO_EN is not defined, have no FIFO: in_ready = (state == IDLE), including the done cycle; in_valid while busy is ignored.

Verification
REQ-028 SHALL cover: reset, send opcode 4'hA, instr 12'h5C3 -> dip_out 8'h3A for 10 cycles with btn high cycles 3..6 after SETUP start, then 8'h5C, done at cycle 21 after acceptance.
REQ-029 SHALL cover: instr_tx driving the instruction loader in the top level, send opcode 4'h1, instr 12'hABC -> loader holds opcode 4'h1, instr 12'hABC and its second-byte flag back to 0.
REQ-030 SHALL cover: rst_n low for one cycle during byte1 HIGH -> btn_out 0 next cycle, dip_out 8'h00, no done, in_ready 1.
REQ-031 SHALL cover (no FIFO): in_valid held high with new data while busy -> in_ready 0, data ignored, next acceptance coincides with done cycle.
REQ-032 SHALL cover (INSTR_TX_FIFO_EN): push 5 instructions back-to-back -> in_ready drops after 4 buffered while first sends, all 5 sent in order, 4 done pulses spaced 21 cycles then the fifth.
REQ-033 SHALL cover: SETUP_CYCLES = 1, HOLD_CYCLES = 3 -> 14 non-IDLE cycles per instruction, 2 btn_out rising edges.
